// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 register file: register numbers, exception codes,
// except-vector bit positions and Status/Cause field layout.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    localparam int unsigned EX_ADEL_IF = 6;
    localparam int unsigned EX_BP      = 5;
    localparam int unsigned EX_SYS     = 4;
    localparam int unsigned EX_RI      = 3;
    localparam int unsigned EX_OV      = 2;
    localparam int unsigned EX_ADEL_D  = 1;
    localparam int unsigned EX_ADES    = 0;

    localparam int unsigned ST_IE  = 0;
    localparam int unsigned ST_EXL = 1;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    localparam int unsigned CA_BD     = 31;
    localparam int unsigned CA_TI     = 30;
    localparam int unsigned CA_IP_SW  = 8;
    localparam int unsigned CA_IP_HW  = 10;
    localparam int unsigned CA_EXCODE = 2;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches one cycle
// after a post-reset Count==Compare match and is cleared by a Compare write.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        tick_q, tick_d;
    logic        armed_q, armed_d;
    logic        ti_q, ti_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;

    always_comb begin
        tick_d    = ~tick_q;
        armed_d   = armed_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_we) begin
            count_d = wdata;
        end else if (tick_q) begin
            count_d = count_q + 32'd1;
            armed_d = 1'b1;
        end
        // Both registers are 0 straight out of reset; only match once Count has moved.
        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end else if (armed_q && (count_q == compare_q)) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= 1'b0;
            armed_q   <= 1'b0;
            ti_q      <= 1'b0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
        end else begin
            tick_q    <= tick_d;
            armed_q   <= armed_d;
            ti_q      <= ti_d;
            count_q   <= count_d;
            compare_q <= compare_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file and exception commit unit: holds Status/Cause/EPC/BadVAddr,
// prioritises exceptions and interrupts, and drives the pipeline flush/redirect.
module cp0_regfile
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        mtc0_we,
    input  logic [4:0]  c0_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [6:0]  except,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic        eret,
    input  logic [31:0] bad_vaddr,
    input  logic [5:0]  hw_int,
    output logic        flush,
    output logic [31:0] exc_pc,
    output logic [31:0] epc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        bd_q, bd_d;
    logic [4:0]  excode_q, excode_d;
    logic [1:0]  ip_sw_q, ip_sw_d;

    logic [31:0] count, compare, cause;
    logic        ti;
    logic [5:0]  ip_hw;
    logic        int_req, exc, eret_take, wr_en;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [4:0]  excode_sel;
    logic        bva_pc, bva_data;

    // IP[15:10] is a live mirror, so a same-cycle mtc0 can never override it.
    assign ip_hw = {hw_int[5] | ti, hw_int[4:0]};
    assign cause = {bd_q, ti, 14'd0, ip_hw, ip_sw_q, 1'b0, excode_q, 2'b00};

    assign int_req   = status_q[ST_IE] & ~status_q[ST_EXL] &
                       (|(cause[15:8] & status_q[15:8]));
    assign exc       = valid & ~reset & (int_req | (|except));
    assign eret_take = valid & ~reset & eret & ~exc;
    assign wr_en     = valid & mtc0_we & ~exc;

    assign wr_count   = wr_en & (c0_addr == REG_COUNT);
    assign wr_compare = wr_en & (c0_addr == REG_COMPARE);
    assign wr_status  = wr_en & (c0_addr == REG_STATUS);
    assign wr_cause   = wr_en & (c0_addr == REG_CAUSE);
    assign wr_epc     = wr_en & (c0_addr == REG_EPC);

    always_comb begin
        excode_sel = EXC_INT;
        bva_pc     = 1'b0;
        bva_data   = 1'b0;
        if (int_req) begin
            excode_sel = EXC_INT;
        end else if (except[EX_ADEL_IF]) begin
            excode_sel = EXC_ADEL;
            bva_pc     = 1'b1;
        end else if (except[EX_RI]) begin
            excode_sel = EXC_RI;
        end else if (except[EX_OV]) begin
            excode_sel = EXC_OV;
        end else if (except[EX_SYS]) begin
            excode_sel = EXC_SYS;
        end else if (except[EX_BP]) begin
            excode_sel = EXC_BP;
        end else if (except[EX_ADEL_D]) begin
            excode_sel = EXC_ADEL;
            bva_data   = 1'b1;
        end else if (except[EX_ADES]) begin
            excode_sel = EXC_ADES;
            bva_data   = 1'b1;
        end
    end

    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        bd_d       = bd_q;
        excode_d   = excode_q;
        ip_sw_d    = ip_sw_q;
        if (exc) begin
            excode_d         = excode_sel;
            status_d[ST_EXL] = 1'b1;
            // A nested exception keeps the EPC/BD of the original fault.
            if (!status_q[ST_EXL]) begin
                epc_d = bd ? (pc - 32'd4) : pc;
                bd_d  = bd;
            end
            if (bva_pc) begin
                badvaddr_d = pc;
            end else if (bva_data) begin
                badvaddr_d = bad_vaddr;
            end
        end else begin
            if (eret_take) begin
                status_d[ST_EXL] = 1'b0;
            end
            if (wr_status) begin
                status_d = (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
            end
            if (wr_cause) begin
                ip_sw_d = wdata[CA_IP_SW +: 2];
            end
            if (wr_epc) begin
                epc_d = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q   <= STATUS_RESET;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            bd_q       <= 1'b0;
            excode_q   <= EXC_INT;
            ip_sw_q    <= 2'b00;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            bd_q       <= bd_d;
            excode_q   <= excode_d;
            ip_sw_q    <= ip_sw_d;
        end
    end

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_comb begin
        rdata = 32'd0;
        unique case (c0_addr)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count;
            REG_COMPARE:  rdata = compare;
            REG_STATUS:   rdata = status_q;
            REG_CAUSE:    rdata = cause;
            REG_EPC:      rdata = epc_q;
            default:      rdata = 32'd0;
        endcase
    end

    assign flush    = exc | eret_take;
    assign exc_pc   = exc ? EXC_VECTOR : (eret_take ? epc_q : 32'd0);
    assign epc_o    = epc_q;
    assign status_o = status_q;
    assign cause_o  = cause;

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file and exception commit unit for the five-stage MIPS core. It consumes the CP0 side-channel the decode stage produces (mtc0 write enable, CP0 address, 7-bit exception vector, branch-delay flag, eret) once the instruction reaches the commit point. It also holds BadVAddr/Count/Compare/Status/Cause/EPC, arbitrates exceptions and interrupts, and drives the pipeline flush and redirect PC. The Count/Compare timer raises hardware interrupt IP7.

## Interface
- No parameters; constants live in `cp0_pkg`.
- `clk` in 1: sole clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high.
- `valid` in 1: commit-stage slot holds a real instruction (not a bubble).
- `mtc0_we` in 1: write `wdata` to CP0 register `c0_addr`.
- `c0_addr` in 5: CP0 register number for read and write.
- `wdata` in 32: mtc0 data (rt value).
- `rdata` out 32: combinational read of `c0_addr` for mfc0; unimplemented numbers read 0.
- `except` in 7: [6] AdEL fetch, [5] Bp, [4] Sys, [3] RI, [2] Ov, [1] AdEL data, [0] AdES.
- `pc` in 32: PC of the committing instruction.
- `bd` in 1: committing instruction sits in a delay slot.
- `eret` in 1: committing instruction is eret.
- `bad_vaddr` in 32: faulting data address for except[1:0].
- `hw_int` in 6: external interrupt lines, level-sensitive; [5] is ORed with the timer interrupt TI.
- `flush` out 1: kill IF..commit younger instructions; combinational.
- `exc_pc` out 32: redirect target, valid when `flush`.
- `epc_o`, `status_o`, `cause_o` out 32 each: register views.

## Operation
- Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
- **Status:**
  - Reset value 0x0040_0000 (BEV=1).
  - Writable bits IM[15:8], EXL[1], IE[0]; all other bits read as their constants.
- **Cause:**
  - BD[31] and TI[30] are read-only.
  - IP[15:10] mirror `{hw_int[5]|TI, hw_int[4:0]}` every cycle.
  - IP[9:8] are software-writable.
  - ExcCode[6:2].
  - Reset value 0.
- EPC and BadVAddr reset to 0. EPC is mtc0-writable; BadVAddr is not.
- **Interrupt pending:** `int_req = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM)`.
- **Exception request:** `exc = valid & (int_req | |except)`. Priority and ExcCode, highest first:
  - Int 0x00
  - AdEL fetch 0x04
  - RI 0x0A
  - Ov 0x0C
  - Sys 0x08
  - Bp 0x09
  - AdEL data 0x04
  - AdES 0x05
- **On exc (registered at the edge):**
  - ExcCode updated; EXL<=1.
  - If EXL was 0: EPC <= bd ? pc-4 : pc, and Cause.BD <= bd. If EXL was already 1, EPC and BD are held.
  - BadVAddr <= pc for AdEL fetch, `bad_vaddr` for data AdEL/AdES, otherwise unchanged.
  - `flush`=1 and `exc_pc`=0xBFC0_0380 in the same cycle.
- **On `valid & eret` with no exc:** EXL<=0, `flush`=1, `exc_pc`=EPC as currently registered.
- **Simultaneous events:**
  - exc suppresses mtc0 and eret from the same slot.
  - An mtc0 to Cause/Status in the same cycle as a hardware IP change: the IP mirror wins for IP[15:10].
- `flush`=0 and `exc_pc`=0 whenever neither an exception nor an eret commits.

## Timing
- **Count:**
  - Increments every second cycle via a 1-bit tick toggle, which resets to 0.
  - Count resets to 0 and wraps 0xFFFF_FFFF -> 0.
  - mtc0 Count overrides the increment in that cycle.
- **Compare/TI:**
  - Compare resets to 0.
  - TI sets one cycle after Count == Compare, and stays set until mtc0 Compare, which clears it in the same write cycle.
  - TI is not set while Count==Compare immediately after reset (both 0); matching is qualified by a post-reset increment.
- mtc0 writes are visible to `rdata` from the next cycle. `rdata` has no internal forwarding of the same-cycle write.
- Exception and eret latency to redirect: 0 cycles (combinational flush). State update: 1 edge.
- `reset` mid-exception: all registers return to reset values on that edge, and `flush` deasserts.

## Structure
- `cp0_pkg`:
  - register numbers, ExcCode constants, `EXC_VECTOR=32'hBFC0_0380`;
  - `except` bit indices;
  - Status and Cause field positions and writable masks.
- Sub-module `cp0_timer`: Count, Compare, tick, TI. Ports are `clk`, `reset`, write strobes, write data, `count`, `compare`, `ti`.
- Priority encoder stays inline.

## Test plan
- **Reset:** after reset, Status=0x0040_0000, Cause=0, EPC=0, Count stays 0 for one cycle then reads 1 after 2 cycles, `flush`=0.
- **Syscall in delay slot:** except=7'b001_0000, bd=1, pc=0x8000_0104 -> flush=1, exc_pc=0xBFC0_0380; next cycle EPC=0x8000_0100, Cause.BD=1, ExcCode=0x08, EXL=1.
- **Nested exception:** Ov with EXL already 1 -> EPC unchanged, ExcCode=0x0C, flush=1.
- **Data AdES:** bad_vaddr=0x8000_0003 -> BadVAddr=0x8000_0003, ExcCode=0x05. With except[6] also set, pc is taken instead and ExcCode=0x04.
- **Timer interrupt:**
  - Setup: mtc0 Compare=10, Status IM7=1 IE=1.
  - Cause.TI=1 one cycle after Count reaches 10; the next valid slot gets flush with ExcCode=0.
  - mtc0 Compare clears TI.
- **eret:** EPC=0x8000_0200, EXL=1 -> flush=1, exc_pc=0x8000_0200, EXL=0. Same slot with except[3] -> RI exception taken, EXL stays 1.
